// File: rtl/mandelbrot_pipeline_if.sv
// Video stream bundle between the timing generator and the Mandelbrot engine:
// pixel coordinate plus syncs in, RGB plus delayed syncs out.
interface mandelbrot_pipeline_if;
  logic        i_de;
  logic        i_hs;
  logic        i_vs;
  logic [10:0] i_x;
  logic [10:0] i_y;
  logic        o_de;
  logic        o_hs;
  logic        o_vs;
  logic [23:0] o_rgb;

  modport master (
    output i_de, i_hs, i_vs, i_x, i_y,
    input  o_de, o_hs, o_vs, o_rgb
  );

  modport slave (
    input  i_de, i_hs, i_vs, i_x, i_y,
    output o_de, o_hs, o_vs, o_rgb
  );
endinterface

// File: rtl/mandelbrot_pipeline.sv
// Unrolled Mandelbrot engine: map stage, MAX_ITER iteration stages, colour stage.
// One pixel per clock; syncs ride alongside so outputs feed the encoder directly.
module mandelbrot_pipeline #(
  parameter int W        = 16,
  parameter int FRAC     = 12,
  parameter int MAX_ITER = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [W-1:0]         i_view_x0,
  input  logic [W-1:0]         i_view_y0,
  input  logic [W-1:0]         i_step,
  mandelbrot_pipeline_if.slave vid
);
  localparam int ZW = W + 2;
  localparam int PW = 2 * ZW;
  localparam int N  = MAX_ITER;
  localparam logic [7:0]        CNT_MAX = 8'(MAX_ITER);
  localparam logic signed [PW:0] FOUR   = (PW+1)'(4) <<< FRAC;

  logic [W-1:0]  x0, y0, step;
  logic          vs_prev;
  logic [W+10:0] prod_x, prod_y;
  logic [W-1:0]  c_re, c_im;

  logic signed [ZW-1:0] zr [0:N];
  logic signed [ZW-1:0] zi [0:N];
  logic signed [W-1:0]  cr [0:N];
  logic signed [W-1:0]  ci [0:N];
  logic [7:0]           cnt [0:N];
  logic                 esc [0:N];
  logic                 de_p [0:N];
  logic                 hs_p [0:N];
  logic                 vs_p [0:N];

  logic signed [ZW-1:0] zr_n [1:N];
  logic signed [ZW-1:0] zi_n [1:N];
  logic [7:0]           cnt_n [1:N];
  logic                 esc_n [1:N];

  logic        de_q, hs_q, vs_q;
  logic [23:0] rgb_q;

  // Coordinate mapping wraps modulo 2^W by design.
  assign prod_x = (W+11)'(vid.i_x) * (W+11)'(step);
  assign prod_y = (W+11)'(vid.i_y) * (W+11)'(step);
  assign c_re   = x0 + prod_x[W-1:0];
  assign c_im   = y0 + prod_y[W-1:0];

  // Escape test uses untruncated squares so a freshly updated |z| up to 12
  // cannot wrap into a false "still bounded" magnitude.
  always_comb begin
    logic signed [PW-1:0] zr_e, zi_e, sq_r, sq_i, pr;
    logic signed [PW:0]   mag;
    zr_e = '0;
    zi_e = '0;
    sq_r = '0;
    sq_i = '0;
    pr   = '0;
    mag  = '0;
    for (int k = 1; k <= N; k++) begin
      zr_e = PW'(zr[k-1]);
      zi_e = PW'(zi[k-1]);
      sq_r = (zr_e * zr_e) >>> FRAC;
      sq_i = (zi_e * zi_e) >>> FRAC;
      pr   = (zr_e * zi_e) >>> FRAC;
      mag  = (PW+1)'(sq_r) + (PW+1)'(sq_i);
      zr_n[k]  = zr[k-1];
      zi_n[k]  = zi[k-1];
      cnt_n[k] = cnt[k-1];
      esc_n[k] = esc[k-1];
      if (!esc[k-1]) begin
        if (mag > FOUR) begin
          esc_n[k] = 1'b1;
        end else begin
          zr_n[k]  = ZW'(sq_r - sq_i + PW'(cr[k-1]));
          zi_n[k]  = ZW'((pr <<< 1) + PW'(ci[k-1]));
          cnt_n[k] = cnt[k-1] + 8'd1;
        end
      end
    end
  end

  // View registers track the ports during reset and latch on each vsync rise.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      x0      <= i_view_x0;
      y0      <= i_view_y0;
      step    <= i_step;
      vs_prev <= 1'b0;
      for (int k = 0; k <= N; k++) begin
        zr[k]   <= '0;
        zi[k]   <= '0;
        cr[k]   <= '0;
        ci[k]   <= '0;
        cnt[k]  <= '0;
        esc[k]  <= 1'b0;
        de_p[k] <= 1'b0;
        hs_p[k] <= 1'b0;
        vs_p[k] <= 1'b0;
      end
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      vs_prev <= vid.i_vs;
      if (vid.i_vs && !vs_prev) begin
        x0   <= i_view_x0;
        y0   <= i_view_y0;
        step <= i_step;
      end
      zr[0]   <= '0;
      zi[0]   <= '0;
      cr[0]   <= c_re;
      ci[0]   <= c_im;
      cnt[0]  <= '0;
      esc[0]  <= 1'b0;
      de_p[0] <= vid.i_de;
      hs_p[0] <= vid.i_hs;
      vs_p[0] <= vid.i_vs;
      for (int k = 1; k <= N; k++) begin
        zr[k]   <= zr_n[k];
        zi[k]   <= zi_n[k];
        cr[k]   <= cr[k-1];
        ci[k]   <= ci[k-1];
        cnt[k]  <= cnt_n[k];
        esc[k]  <= esc_n[k];
        de_p[k] <= de_p[k-1];
        hs_p[k] <= hs_p[k-1];
        vs_p[k] <= vs_p[k-1];
      end
      de_q <= de_p[N];
      hs_q <= hs_p[N];
      vs_q <= vs_p[N];
      if (de_p[N] && cnt[N] != CNT_MAX)
        rgb_q <= {cnt[N], 8'(cnt[N] << 1), ~cnt[N]};
      else
        rgb_q <= '0;
    end
  end

  assign vid.o_de  = de_q;
  assign vid.o_hs  = hs_q;
  assign vid.o_vs  = vs_q;
  assign vid.o_rgb = rgb_q;
endmodule
